// File: rtl/tlb_cmd_unit.sv
// tlb_cmd_unit
//   Executes one TLB maintenance op at a time (TLBSRCH, TLBRD, TLBWR, TLBFILL,
//   INVTLB) against a TLBNUM-entry TLB and returns the CSR updates that op
//   produces. The op is accepted with a valid/ready handshake. The unit drives
//   the TLB write, read, search-1 and invtlb ports for one cycle. It then
//   presents a one-cycle response.
//   Timing: accept in cycle N, TLB strobe in N+1, response in N+2, ready in N+3.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   req_*                op handshake, opcode and INVTLB operands
//   csr_*                current TLBIDX/TLBEHI/TLBELO0/1/ASID/ESTAT.Ecode values,
//                        held stable by the pipeline from accept to response
//   tlb_s_*              search port 1; tlb_s_sel claims it from the pipeline
//   tlb_we, tlb_w_*      entry write port
//   tlb_r_index, tlb_r_* entry read port
//   tlb_inv_valid/op     INVTLB strobe (key shared with search port 1)
//   resp_*               completion pulse plus CSR write enables and values
module tlb_cmd_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [18:0]     req_inv_vppn,
  input  logic [IDXW-1:0] csr_idx_index,
  input  logic [5:0]      csr_idx_ps,
  input  logic            csr_idx_ne,
  input  logic [18:0]     csr_ehi_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [31:0]     csr_elo0,
  input  logic [31:0]     csr_elo1,
  input  logic [5:0]      csr_estat_ecode,
  output logic            tlb_s_sel,
  output logic [18:0]     tlb_s_vppn,
  output logic [9:0]      tlb_s_asid,
  input  logic            tlb_s_found,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic [18:0]     tlb_w_vppn,
  output logic [5:0]      tlb_w_ps,
  output logic [9:0]      tlb_w_asid,
  output logic            tlb_w_g,
  output logic [19:0]     tlb_w_ppn0,
  output logic [1:0]      tlb_w_plv0,
  output logic [1:0]      tlb_w_mat0,
  output logic            tlb_w_d0,
  output logic            tlb_w_v0,
  output logic [19:0]     tlb_w_ppn1,
  output logic [1:0]      tlb_w_plv1,
  output logic [1:0]      tlb_w_mat1,
  output logic            tlb_w_d1,
  output logic            tlb_w_v1,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic [18:0]     tlb_r_vppn,
  input  logic [5:0]      tlb_r_ps,
  input  logic [9:0]      tlb_r_asid,
  input  logic            tlb_r_g,
  input  logic [19:0]     tlb_r_ppn0,
  input  logic [1:0]      tlb_r_plv0,
  input  logic [1:0]      tlb_r_mat0,
  input  logic            tlb_r_d0,
  input  logic            tlb_r_v0,
  input  logic [19:0]     tlb_r_ppn1,
  input  logic [1:0]      tlb_r_plv1,
  input  logic [1:0]      tlb_r_mat1,
  input  logic            tlb_r_d1,
  input  logic            tlb_r_v1,
  output logic            tlb_inv_valid,
  output logic [4:0]      tlb_inv_op,
  output logic            resp_valid,
  output logic            resp_ine,
  output logic            resp_idx_we,
  output logic            resp_idx_index_we,
  output logic [IDXW-1:0] resp_idx_index,
  output logic [5:0]      resp_idx_ps,
  output logic            resp_idx_ne,
  output logic            resp_ent_we,
  output logic [18:0]     resp_ehi_vppn,
  output logic [31:0]     resp_elo0,
  output logic [31:0]     resp_elo1,
  output logic [9:0]      resp_asid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef struct packed {
    logic [2:0]      op;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [18:0]     inv_vppn;
    logic [IDXW-1:0] fill_idx;
  } req_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } ent_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] fill_cnt;
  req_t            req_q;
  logic            s_found_q;
  logic [IDXW-1:0] s_index_q;
  ent_t            rd_q;
  logic            accept;
  logic            inv_ok;

  assign accept = req_valid && (state == S_IDLE);
  // INVTLB ops 7..31 are reserved: they raise INE and leave the TLB alone
  assign inv_ok = (req_q.inv_op <= 5'd6);

  // Packs a read-back page half into the TLBELO CSR layout.
  function automatic logic [31:0] mk_elo(input logic [19:0] ppn, input logic g,
                                         input logic [1:0] mat, input logic [1:0] plv,
                                         input logic d, input logic v);
    return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
  endfunction

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Free-running fill pointer; TLBFILL uses whatever it held at accept.
  always_ff @(posedge clk) begin
    if (reset)                               fill_cnt <= '0;
    else if (fill_cnt == IDXW'(TLBNUM - 1))  fill_cnt <= '0;
    else                                     fill_cnt <= fill_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.op       <= req_op;
      req_q.inv_op   <= req_inv_op;
      req_q.inv_asid <= req_inv_asid;
      req_q.inv_vppn <= req_inv_vppn;
      req_q.fill_idx <= fill_cnt;
    end
  end

  // Search and read results are captured at the end of ISSUE.
  // The response is then built from registers, not from the TLB's combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_found_q <= 1'b0;
      s_index_q <= '0;
      rd_q      <= '0;
    end else if (state == S_ISSUE) begin
      s_found_q <= tlb_s_found;
      s_index_q <= tlb_s_index;
      rd_q.e    <= tlb_r_e;
      rd_q.vppn <= tlb_r_vppn;
      rd_q.ps   <= tlb_r_ps;
      rd_q.asid <= tlb_r_asid;
      rd_q.g    <= tlb_r_g;
      rd_q.ppn0 <= tlb_r_ppn0;
      rd_q.plv0 <= tlb_r_plv0;
      rd_q.mat0 <= tlb_r_mat0;
      rd_q.d0   <= tlb_r_d0;
      rd_q.v0   <= tlb_r_v0;
      rd_q.ppn1 <= tlb_r_ppn1;
      rd_q.plv1 <= tlb_r_plv1;
      rd_q.mat1 <= tlb_r_mat1;
      rd_q.d1   <= tlb_r_d1;
      rd_q.v1   <= tlb_r_v1;
    end
  end

  // --------------------------------------------------- write / read fields
  // The write data only matters while tlb_we is high, so it is left unconditioned.
  // During a refill (Ecode 3F), TLBFILL/TLBWR always produce a valid entry.
  assign tlb_w_index = (req_q.op == OP_FILL) ? req_q.fill_idx : csr_idx_index;
  assign tlb_w_e     = (csr_estat_ecode == 6'h3F) | ~csr_idx_ne;
  assign tlb_w_vppn  = csr_ehi_vppn;
  assign tlb_w_ps    = csr_idx_ps;
  assign tlb_w_asid  = csr_asid;
  assign tlb_w_g     = csr_elo0[6] & csr_elo1[6];
  assign tlb_w_ppn0  = csr_elo0[27:8];
  assign tlb_w_plv0  = csr_elo0[3:2];
  assign tlb_w_mat0  = csr_elo0[5:4];
  assign tlb_w_d0    = csr_elo0[1];
  assign tlb_w_v0    = csr_elo0[0];
  assign tlb_w_ppn1  = csr_elo1[27:8];
  assign tlb_w_plv1  = csr_elo1[3:2];
  assign tlb_w_mat1  = csr_elo1[5:4];
  assign tlb_w_d1    = csr_elo1[1];
  assign tlb_w_v1    = csr_elo1[0];
  assign tlb_r_index = csr_idx_index;

  // Reserved ELO bits have no TLB storage.
  logic unused_elo_bits;
  assign unused_elo_bits = ^{csr_elo0[31:28], csr_elo0[7], csr_elo1[31:28], csr_elo1[7]};

  // ------------------------------------------- next state and strobe/resp
  // Strobes and the response are masked by reset in the same cycle.
  // A reset that lands during ISSUE therefore leaves the TLB untouched.
  always_comb begin
    state_nxt         = state;
    req_ready         = 1'b0;
    tlb_s_sel         = 1'b0;
    tlb_s_vppn        = '0;
    tlb_s_asid        = '0;
    tlb_we            = 1'b0;
    tlb_inv_valid     = 1'b0;
    tlb_inv_op        = '0;
    resp_valid        = 1'b0;
    resp_ine          = 1'b0;
    resp_idx_we       = 1'b0;
    resp_idx_index_we = 1'b0;
    resp_idx_index    = '0;
    resp_idx_ps       = '0;
    resp_idx_ne       = 1'b0;
    resp_ent_we       = 1'b0;
    resp_ehi_vppn     = '0;
    resp_elo0         = '0;
    resp_elo1         = '0;
    resp_asid         = '0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ISSUE;
      end

      S_ISSUE: begin
        state_nxt = S_RESP;
        if (!reset) begin
          case (req_q.op)
            OP_SRCH: begin
              tlb_s_sel  = 1'b1;
              tlb_s_vppn = csr_ehi_vppn;
              tlb_s_asid = csr_asid;
            end
            OP_WR, OP_FILL: tlb_we = 1'b1;
            OP_INV: begin
              if (inv_ok) begin
                tlb_inv_valid = 1'b1;
                tlb_inv_op    = req_q.inv_op;
                tlb_s_sel     = 1'b1;
                tlb_s_vppn    = req_q.inv_vppn;
                tlb_s_asid    = req_q.inv_asid;
              end
            end
            default: ;
          endcase
        end
      end

      S_RESP: begin
        state_nxt = S_IDLE;
        if (!reset) begin
          resp_valid = 1'b1;
          case (req_q.op)
            OP_SRCH: begin
              resp_idx_we = 1'b1;
              resp_idx_ps = csr_idx_ps;
              if (s_found_q) begin
                resp_idx_index_we = 1'b1;
                resp_idx_index    = s_index_q;
              end else begin
                resp_idx_ne = 1'b1;
              end
            end
            OP_RD: begin
              resp_idx_we = 1'b1;
              resp_ent_we = 1'b1;
              if (rd_q.e) begin
                resp_idx_ps   = rd_q.ps;
                resp_ehi_vppn = rd_q.vppn;
                resp_asid     = rd_q.asid;
                resp_elo0     = mk_elo(rd_q.ppn0, rd_q.g, rd_q.mat0, rd_q.plv0, rd_q.d0, rd_q.v0);
                resp_elo1     = mk_elo(rd_q.ppn1, rd_q.g, rd_q.mat1, rd_q.plv1, rd_q.d1, rd_q.v1);
              end else begin
                resp_idx_ne = 1'b1;
              end
            end
            OP_INV: resp_ine = ~inv_ok;
            default: ;
          endcase
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_cmd_unit.sv
// tb_tlb_cmd_unit
//   Drives directed ops into tlb_cmd_unit against a behavioural 16-entry TLB.
//   A per-cycle reference model predicts every output from the op rules.
//   The directed sequence also pins hand-computed literal values.
module tb_tlb_cmd_unit;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_inv_asid;
  logic [18:0] req_inv_vppn;
  logic [3:0]  csr_idx_index;
  logic [5:0]  csr_idx_ps;
  logic        csr_idx_ne;
  logic [18:0] csr_ehi_vppn;
  logic [9:0]  csr_asid;
  logic [31:0] csr_elo0, csr_elo1;
  logic [5:0]  csr_estat_ecode;
  logic        tlb_s_sel, tlb_s_found;
  logic [18:0] tlb_s_vppn;
  logic [9:0]  tlb_s_asid;
  logic [3:0]  tlb_s_index;
  logic        tlb_we, tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic [3:0]  tlb_w_index, tlb_r_index;
  logic [18:0] tlb_w_vppn;
  logic [5:0]  tlb_w_ps;
  logic [9:0]  tlb_w_asid;
  logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
  logic [1:0]  tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
  logic        tlb_r_e, tlb_r_g, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic [18:0] tlb_r_vppn;
  logic [5:0]  tlb_r_ps;
  logic [9:0]  tlb_r_asid;
  logic [19:0] tlb_r_ppn0, tlb_r_ppn1;
  logic [1:0]  tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
  logic        tlb_inv_valid;
  logic [4:0]  tlb_inv_op;
  logic        resp_valid, resp_ine, resp_idx_we, resp_idx_index_we, resp_idx_ne, resp_ent_we;
  logic [3:0]  resp_idx_index;
  logic [5:0]  resp_idx_ps;
  logic [18:0] resp_ehi_vppn;
  logic [31:0] resp_elo0, resp_elo1;
  logic [9:0]  resp_asid;

  tlb_cmd_unit #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
    .csr_idx_index(csr_idx_index), .csr_idx_ps(csr_idx_ps), .csr_idx_ne(csr_idx_ne),
    .csr_ehi_vppn(csr_ehi_vppn), .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .csr_estat_ecode(csr_estat_ecode),
    .tlb_s_sel(tlb_s_sel), .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
    .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
    .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
    .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
    .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
    .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
    .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
    .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
    .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
    .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
    .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
    .resp_valid(resp_valid), .resp_ine(resp_ine), .resp_idx_we(resp_idx_we),
    .resp_idx_index_we(resp_idx_index_we), .resp_idx_index(resp_idx_index),
    .resp_idx_ps(resp_idx_ps), .resp_idx_ne(resp_idx_ne), .resp_ent_we(resp_ent_we),
    .resp_ehi_vppn(resp_ehi_vppn), .resp_elo0(resp_elo0), .resp_elo1(resp_elo1),
    .resp_asid(resp_asid)
  );

  // ------------------------------------------------ behavioural TLB (env)
  typedef struct packed {
    logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
    logic [19:0] ppn0; logic [1:0] plv0, mat0; logic d0, v0;
    logic [19:0] ppn1; logic [1:0] plv1, mat1; logic d1, v1;
  } ent_t;

  ent_t tlb [TLBNUM];

  // All pages in this bench are 4 KB, so the match compares the whole VPPN.
  function automatic logic hit(input ent_t t, input logic [18:0] v, input logic [9:0] a);
    return t.e && (t.vppn == v) && (t.g || (t.asid == a));
  endfunction

  function automatic logic inv_hit(input ent_t t, input logic [4:0] op,
                                   input logic [18:0] v, input logic [9:0] a);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return t.g;
      5'd3:       return !t.g;
      5'd4:       return !t.g && (t.asid == a);
      5'd5:       return !t.g && (t.asid == a) && (t.vppn == v);
      5'd6:       return (t.g || (t.asid == a)) && (t.vppn == v);
      default:    return 1'b0;
    endcase
  endfunction

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (hit(tlb[i], tlb_s_vppn, tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = 4'(i);
      end
  end

  assign tlb_r_e = tlb[tlb_r_index].e;       assign tlb_r_vppn = tlb[tlb_r_index].vppn;
  assign tlb_r_ps = tlb[tlb_r_index].ps;     assign tlb_r_asid = tlb[tlb_r_index].asid;
  assign tlb_r_g = tlb[tlb_r_index].g;
  assign tlb_r_ppn0 = tlb[tlb_r_index].ppn0; assign tlb_r_plv0 = tlb[tlb_r_index].plv0;
  assign tlb_r_mat0 = tlb[tlb_r_index].mat0; assign tlb_r_d0 = tlb[tlb_r_index].d0;
  assign tlb_r_v0 = tlb[tlb_r_index].v0;
  assign tlb_r_ppn1 = tlb[tlb_r_index].ppn1; assign tlb_r_plv1 = tlb[tlb_r_index].plv1;
  assign tlb_r_mat1 = tlb[tlb_r_index].mat1; assign tlb_r_d1 = tlb[tlb_r_index].d1;
  assign tlb_r_v1 = tlb[tlb_r_index].v1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
    end else begin
      if (tlb_we)
        tlb[tlb_w_index] <= '{e:tlb_w_e, vppn:tlb_w_vppn, ps:tlb_w_ps, asid:tlb_w_asid, g:tlb_w_g,
                              ppn0:tlb_w_ppn0, plv0:tlb_w_plv0, mat0:tlb_w_mat0, d0:tlb_w_d0, v0:tlb_w_v0,
                              ppn1:tlb_w_ppn1, plv1:tlb_w_plv1, mat1:tlb_w_mat1, d1:tlb_w_d1, v1:tlb_w_v1};
      if (tlb_inv_valid)
        for (int i = 0; i < TLBNUM; i++)
          if (inv_hit(tlb[i], tlb_inv_op, tlb_s_vppn, tlb_s_asid)) tlb[i].e <= 1'b0;
    end
  end

  // ------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] elo_val(input logic [19:0] ppn, input logic g, input logic [1:0] mat,
                                          input logic [1:0] plv, input logic d, input logic v);
    return (32'(ppn) << 8) + (32'(g) << 6) + (32'(mat) << 4) + (32'(plv) << 2) + (32'(d) << 1) + 32'(v);
  endfunction

  // Reference model: phase counts cycles since accept (0 idle, 1 strobe, 2 response).
  int          m_phase = 0;
  int          m_fill  = 0;
  bit          chk_en  = 0;
  logic [2:0]  m_op;
  logic [4:0]  m_inv_op;
  logic [9:0]  m_inv_asid;
  logic [18:0] m_inv_vppn;
  int          m_fill_s;
  logic        m_found;
  logic [3:0]  m_index;
  ent_t        m_rd;

  always @(negedge clk) begin
    logic e_we, e_inv, e_sel;
    logic [28:0]  e_key;
    logic [93:0]  e_w;
    logic [108:0] e_resp;
    logic [3:0]   e_ii;
    logic [5:0]   e_ps;
    logic e_ine, e_iwe, e_iiwe, e_ne, e_ewe;
    logic [18:0]  e_vppn;
    logic [31:0]  e_elo0, e_elo1;
    logic [9:0]   e_asid;
    bool_active: begin end
    if (chk_en) begin
      e_we = 0; e_inv = 0; e_sel = 0; e_key = '0;
      if (m_phase == 1 && !reset) begin
        if (m_op == 3'd0) begin e_sel = 1; e_key = {csr_ehi_vppn, csr_asid}; end
        if (m_op == 3'd2 || m_op == 3'd3) e_we = 1;
        if (m_op == 3'd4 && m_inv_op <= 5'd6) begin
          e_inv = 1; e_sel = 1; e_key = {m_inv_vppn, m_inv_asid};
        end
      end
      chk("req_ready", req_ready, m_phase == 0);
      chk("tlb_we", tlb_we, e_we);
      chk("tlb_inv_valid", tlb_inv_valid, e_inv);
      chk("tlb_s_sel", tlb_s_sel, e_sel);
      if (e_sel) chk("s_key", {tlb_s_vppn, tlb_s_asid}, e_key);
      if (e_inv) chk("inv_op", tlb_inv_op, m_inv_op);
      if (m_phase == 1 && m_op == 3'd1) chk("r_index", tlb_r_index, csr_idx_index);
      if (e_we) begin
        e_w = {(m_op == 3'd3) ? 4'(m_fill_s) : csr_idx_index,
               (csr_estat_ecode == 6'h3F) ? 1'b1 : !csr_idx_ne,
               csr_ehi_vppn, csr_idx_ps, csr_asid, csr_elo0[6] && csr_elo1[6],
               csr_elo0[27:8], csr_elo0[3:2], csr_elo0[5:4], csr_elo0[1], csr_elo0[0],
               csr_elo1[27:8], csr_elo1[3:2], csr_elo1[5:4], csr_elo1[1], csr_elo1[0]};
        chk("w_fields", {tlb_w_index, tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                         tlb_w_ppn0, tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0,
                         tlb_w_ppn1, tlb_w_plv1, tlb_w_mat1, tlb_w_d1, tlb_w_v1}, e_w);
      end
      e_ine = 0; e_iwe = 0; e_iiwe = 0; e_ii = 0; e_ps = 0; e_ne = 0; e_ewe = 0;
      e_vppn = 0; e_elo0 = 0; e_elo1 = 0; e_asid = 0;
      if (m_phase == 2 && !reset) begin
        case (m_op)
          3'd0: begin
            e_iwe = 1; e_ps = csr_idx_ps; e_ne = !m_found;
            if (m_found) begin e_iiwe = 1; e_ii = m_index; end
          end
          3'd1: begin
            e_iwe = 1; e_ewe = 1; e_ne = !m_rd.e;
            if (m_rd.e) begin
              e_ps = m_rd.ps; e_vppn = m_rd.vppn; e_asid = m_rd.asid;
              e_elo0 = elo_val(m_rd.ppn0, m_rd.g, m_rd.mat0, m_rd.plv0, m_rd.d0, m_rd.v0);
              e_elo1 = elo_val(m_rd.ppn1, m_rd.g, m_rd.mat1, m_rd.plv1, m_rd.d1, m_rd.v1);
            end
          end
          3'd4: e_ine = (m_inv_op > 5'd6);
          default: ;
        endcase
      end
      e_resp = {(m_phase == 2 && !reset), e_ine, e_iwe, e_iiwe, e_ii, e_ps, e_ne, e_ewe,
                e_vppn, e_elo0, e_elo1, e_asid};
      chk("resp", {resp_valid, resp_ine, resp_idx_we, resp_idx_index_we, resp_idx_index,
                   resp_idx_ps, resp_idx_ne, resp_ent_we, resp_ehi_vppn, resp_elo0,
                   resp_elo1, resp_asid}, e_resp);
    end
    // capture what the TLB answers for the spec-defined key during the strobe cycle
    if (m_phase == 1 && !reset) begin
      m_found = 0; m_index = 0;
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (hit(tlb[i], csr_ehi_vppn, csr_asid)) begin m_found = 1; m_index = 4'(i); end
      m_rd = tlb[csr_idx_index];
    end
    // advance to the next cycle
    if (reset) begin
      m_phase = 0; m_fill = 0; chk_en = 1;
    end else begin
      if (m_phase == 0 && req_valid) begin
        m_op = req_op; m_inv_op = req_inv_op; m_inv_asid = req_inv_asid;
        m_inv_vppn = req_inv_vppn; m_fill_s = m_fill; m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) m_phase = 0;
      m_fill = (m_fill + 1) % TLBNUM;
    end
  end

  // ------------------------------------------------------------ stimulus
  logic        sn_we, sn_e, sn_g, sn_d0, sn_v0, sn_inv, sn_sel;
  logic [3:0]  sn_widx;
  logic [19:0] sn_ppn0, sn_ppn1;
  logic [1:0]  sn_mat0, sn_plv0;
  logic [4:0]  sn_iop;
  logic [28:0] sn_key;
  logic        sn_rv, sn_ine, sn_iwe, sn_iiwe, sn_ne, sn_ewe;
  logic [3:0]  sn_ii;
  logic [5:0]  sn_ps;
  logic [18:0] sn_vppn;
  logic [31:0] sn_elo0, sn_elo1;
  logic [9:0]  sn_asid;

  task automatic set_csr(input logic [3:0] idx, input logic [5:0] ps, input logic ne,
                         input logic [18:0] vppn, input logic [9:0] asid,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [5:0] ec);
    csr_idx_index = idx; csr_idx_ps = ps; csr_idx_ne = ne; csr_ehi_vppn = vppn;
    csr_asid = asid; csr_elo0 = e0; csr_elo1 = e1; csr_estat_ecode = ec;
  endtask

  // Issues one op from the current cycle; returns #1 into the cycle after the response.
  task automatic do_op(input logic [2:0] op, input logic [4:0] iop,
                       input logic [9:0] ia, input logic [18:0] iv);
    bit got = 0;
    req_op = op; req_inv_op = iop; req_inv_asid = ia; req_inv_vppn = iv; req_valid = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      got = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("accept", got, 1'b1);
    @(negedge clk);
    sn_we = tlb_we; sn_widx = tlb_w_index; sn_e = tlb_w_e; sn_g = tlb_w_g;
    sn_ppn0 = tlb_w_ppn0; sn_ppn1 = tlb_w_ppn1; sn_mat0 = tlb_w_mat0; sn_plv0 = tlb_w_plv0;
    sn_d0 = tlb_w_d0; sn_v0 = tlb_w_v0; sn_inv = tlb_inv_valid; sn_iop = tlb_inv_op;
    sn_sel = tlb_s_sel; sn_key = {tlb_s_vppn, tlb_s_asid};
    @(posedge clk); #1;
    @(negedge clk);
    sn_rv = resp_valid; sn_ine = resp_ine; sn_iwe = resp_idx_we; sn_iiwe = resp_idx_index_we;
    sn_ii = resp_idx_index; sn_ps = resp_idx_ps; sn_ne = resp_idx_ne; sn_ewe = resp_ent_we;
    sn_vppn = resp_ehi_vppn; sn_elo0 = resp_elo0; sn_elo1 = resp_elo1; sn_asid = resp_asid;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    reset = 1; req_valid = 0; req_op = 0; req_inv_op = 0; req_inv_asid = 0; req_inv_vppn = 0;
    set_csr(4'd0, 6'd0, 1'b0, 19'h0, 10'h0, 32'h0, 32'h0, 6'h0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_tlb_we", tlb_we, 1'b0);
    chk("rst_s_sel", tlb_s_sel, 1'b0);
    @(posedge clk); #1;

    // WR entry 5
    set_csr(4'd5, 6'd12, 1'b0, 19'h12345, 10'd3, 32'h0001_2353, 32'h0001_2453, 6'h0);
    do_op(3'd2, 5'd0, 10'd0, 19'd0);
    chk("wr_we", sn_we, 1'b1);     chk("wr_index", sn_widx, 4'd5);
    chk("wr_e", sn_e, 1'b1);       chk("wr_g", sn_g, 1'b1);
    chk("wr_ppn0", sn_ppn0, 20'h00123); chk("wr_ppn1", sn_ppn1, 20'h00124);
    chk("wr_mat0", sn_mat0, 2'd1); chk("wr_plv0", sn_plv0, 2'd0);
    chk("wr_d0", sn_d0, 1'b1);     chk("wr_v0", sn_v0, 1'b1);
    chk("wr_resp", {sn_rv, sn_iwe, sn_ewe}, 3'b100);

    // RD entry 5, then an empty entry
    set_csr(4'd5, 6'd0, 1'b1, 19'h0, 10'd0, 32'h0, 32'h0, 6'h0);
    do_op(3'd1, 5'd0, 10'd0, 19'd0);
    chk("rd_ne", sn_ne, 1'b0);           chk("rd_ps", sn_ps, 6'd12);
    chk("rd_vppn", sn_vppn, 19'h12345);  chk("rd_asid", sn_asid, 10'd3);
    chk("rd_elo0", sn_elo0, 32'h0001_2353); chk("rd_elo1", sn_elo1, 32'h0001_2453);
    chk("rd_we", {sn_iwe, sn_ewe, sn_iiwe}, 3'b110);
    set_csr(4'd9, 6'd12, 1'b0, 19'h1, 10'd1, 32'h0, 32'h0, 6'h0);
    do_op(3'd1, 5'd0, 10'd0, 19'd0);
    chk("rd_empty_ne", sn_ne, 1'b1);  chk("rd_empty_ps", sn_ps, 6'd0);
    chk("rd_empty_ent", {sn_vppn, sn_elo0, sn_elo1, sn_asid}, 93'd0);
    chk("rd_empty_ewe", sn_ewe, 1'b1);

    // SRCH hit and miss
    set_csr(4'd0, 6'd12, 1'b0, 19'h12345, 10'd3, 32'h0, 32'h0, 6'h0);
    do_op(3'd0, 5'd0, 10'd0, 19'd0);
    chk("srch_sel", sn_sel, 1'b1);  chk("srch_key", sn_key, {19'h12345, 10'd3});
    chk("srch_index", sn_ii, 4'd5); chk("srch_ne", sn_ne, 1'b0);
    chk("srch_iiwe", sn_iiwe, 1'b1); chk("srch_ps", sn_ps, 6'd12);
    set_csr(4'd0, 6'd12, 1'b0, 19'h7FFFF, 10'd3, 32'h0, 32'h0, 6'h0);
    do_op(3'd0, 5'd0, 10'd0, 19'd0);
    chk("srch_miss_ne", sn_ne, 1'b1); chk("srch_miss_iiwe", sn_iiwe, 1'b0);

    // two FILLs 3 cycles apart straddling the 15 -> 0 wrap of the fill counter
    set_csr(4'd2, 6'd12, 1'b1, 19'h00AAA, 10'd3, 32'h0000_1011, 32'h0000_2013, 6'h3F);
    for (int i = 0; i < 40 && m_fill != 14; i++) begin @(posedge clk); #1; end
    do_op(3'd3, 5'd0, 10'd0, 19'd0);
    chk("fill1_idx", sn_widx, 4'd14); chk("fill1_e", sn_e, 1'b1); chk("fill1_we", sn_we, 1'b1);
    do_op(3'd3, 5'd0, 10'd0, 19'd0);
    chk("fill2_idx", sn_widx, 4'd1);  chk("fill2_e", sn_e, 1'b1);
    chk("fill2_resp", {sn_rv, sn_iwe, sn_iiwe, sn_ewe}, 4'b1000);

    // rewrite entry 5 as non-global, INVTLB op 5 removes it, SRCH then misses
    set_csr(4'd5, 6'd12, 1'b0, 19'h12345, 10'd3, 32'h0001_2313, 32'h0001_2413, 6'h0);
    do_op(3'd2, 5'd0, 10'd0, 19'd0);
    chk("wr2_g", sn_g, 1'b0);
    do_op(3'd4, 5'd5, 10'd3, 19'h12345);
    chk("inv_valid", sn_inv, 1'b1); chk("inv_op", sn_iop, 5'd5);
    chk("inv_sel", sn_sel, 1'b1);   chk("inv_key", sn_key, {19'h12345, 10'd3});
    chk("inv_ine", sn_ine, 1'b0);   chk("inv_we", sn_we, 1'b0);
    do_op(3'd0, 5'd0, 10'd0, 19'd0);
    chk("srch_after_inv_ne", sn_ne, 1'b1);
    do_op(3'd4, 5'd9, 10'd3, 19'h12345);
    chk("inv9_strobe", sn_inv, 1'b0); chk("inv9_ine", sn_ine, 1'b1); chk("inv9_valid", sn_rv, 1'b1);

    // reserved opcode completes as a no-op
    do_op(3'd7, 5'd0, 10'd0, 19'd0);
    chk("nop_resp", {sn_rv, sn_ine, sn_iwe, sn_iiwe, sn_ewe, sn_we, sn_inv}, 7'b1000000);

    // reset during the strobe cycle of a WR aborts it
    set_csr(4'd7, 6'd12, 1'b0, 19'h00777, 10'd4, 32'h0000_0111, 32'h0000_0111, 6'h0);
    req_op = 3'd2; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; reset = 1;
    @(negedge clk);
    chk("abort_we", tlb_we, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("abort_resp", resp_valid, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
